// File: rtl/gpio_port_bank.sv
// GPIO pad bank: per-bit push-pull/open-drain drive, synchronised and optionally debounced inputs, sticky maskable interrupts.
// Latency: din valid SYNC_STAGES+1 edges after a stable pad, irq_stat one edge later; no backpressure.
module gpio_port_bank #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  inout  wire  [WIDTH-1:0]     pad,
  input  logic [WIDTH-1:0]     dout,
  input  logic [WIDTH-1:0]     dir,
  input  logic [WIDTH-1:0]     od,
  input  logic [WIDTH-1:0]     db_en,
  input  logic                 db_tick,
  input  logic [DB_CNT_W-1:0]  db_thresh,
  input  logic [WIDTH-1:0]     irq_en,
  input  logic [2*WIDTH-1:0]   irq_type,
  input  logic [WIDTH-1:0]     irq_clr,
  output logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     irq_stat,
  output logic                 irq
);

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    sync;
  logic [WIDTH-1:0]    filt;
  logic [WIDTH-1:0]    prev;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic [WIDTH-1:0]    evt;
  logic [DB_CNT_W-1:0] cnt [WIDTH];

  // Open-drain bits only ever pull low; a high dout releases the line.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad[i] = (dir[i] | (od[i] & dout[i])) ? 1'bz : dout[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!db_en[i]) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
        end else if (sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (db_tick) begin
          if (cnt[i] == db_thresh) begin
            filt[i] <= sync[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + DB_CNT_W'(1);
          end
        end
      end
    end
  end

  assign rise = filt & ~prev;
  assign fall = ~filt & prev;

  always_comb begin
    evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (irq_type[2*i +: 2])
        2'b00:   evt[i] = rise[i];
        2'b01:   evt[i] = fall[i];
        2'b10:   evt[i] = rise[i] | fall[i];
        default: evt[i] = filt[i];
      endcase
    end
  end

  // A new event in the same cycle as a clear keeps the status bit set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev     <= '0;
      irq_stat <= '0;
    end else begin
      prev     <= filt;
      irq_stat <= (irq_stat & ~irq_clr) | (irq_en & evt);
    end
  end

  assign din = ((dir | od) & filt) | (~(dir | od) & dout);
  assign irq = |irq_stat;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Randomised and directed stimulus for gpio_port_bank, checked cycle by cycle against a behavioural model.
module tb_gpio_port_bank;
  localparam int W  = 16;
  localparam int SS = 2;
  localparam int CW = 4;

  logic          clk       = 1'b0;
  logic          resetn    = 1'b0;
  wire  [W-1:0]  pad;
  logic [W-1:0]  dout      = '0;
  logic [W-1:0]  dir       = '1;
  logic [W-1:0]  od        = '0;
  logic [W-1:0]  db_en     = '0;
  logic          db_tick   = 1'b0;
  logic [CW-1:0] db_thresh = '0;
  logic [W-1:0]  irq_en    = '0;
  logic [2*W-1:0] irq_type = '0;
  logic [W-1:0]  irq_clr   = '0;
  logic [W-1:0]  ext_val   = '0;
  logic [W-1:0]  din;
  logic [W-1:0]  irq_stat;
  logic          irq;

  logic [W-1:0]  drv;
  logic [W-1:0]  mpad;
  int checks   = 0;
  int failures = 0;

  // Model state: pad samples still in flight, filtered value, previous value, status, mismatch tick counts.
  logic [W-1:0]  hist[$];
  logic [W-1:0]  m_filt, m_prev, m_stat;
  int            m_cnt[W];

  always #5 clk = ~clk;

  // The external world (pull-ups or forcing sources) drives only where the bank is not driving.
  assign drv  = ~dir & ~(od & dout);
  assign mpad = (drv & dout) | (~drv & ext_val);
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign pad[i] = drv[i] ? 1'bz : ext_val[i];
  end

  gpio_port_bank #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .pad(pad), .dout(dout), .dir(dir), .od(od),
    .db_en(db_en), .db_tick(db_tick), .db_thresh(db_thresh), .irq_en(irq_en),
    .irq_type(irq_type), .irq_clr(irq_clr), .din(din), .irq_stat(irq_stat), .irq(irq)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_din();
    return ((dir | od) & m_filt) | (~(dir | od) & dout);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (SS) hist.push_back('0);
    m_filt = '0;
    m_prev = '0;
    m_stat = '0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic r, f, e;
    s = hist.pop_front();
    hist.push_back(mpad);
    for (int i = 0; i < W; i++) begin
      r = m_filt[i] & ~m_prev[i];
      f = ~m_filt[i] & m_prev[i];
      case (irq_type[2*i +: 2])
        2'd0:    e = r;
        2'd1:    e = f;
        2'd2:    e = r | f;
        default: e = m_filt[i];
      endcase
      if (irq_en[i] && e) m_stat[i] = 1'b1;
      else if (irq_clr[i]) m_stat[i] = 1'b0;
    end
    m_prev = m_filt;
    for (int i = 0; i < W; i++) begin
      if (!db_en[i]) begin
        m_filt[i] = s[i];
        m_cnt[i]  = 0;
      end else if (s[i] == m_filt[i]) begin
        m_cnt[i] = 0;
      end else if (db_tick) begin
        if (m_cnt[i] == int'(db_thresh)) begin
          m_filt[i] = s[i];
          m_cnt[i]  = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("din", din, exp_din());
      check("irq_stat", irq_stat, m_stat);
      check("irq", W'(irq), W'(|m_stat));
      check("pad", pad, mpad);
    end
  endtask

  task automatic run_ticks(input int n);
    for (int c = 0; c < n; c++) begin
      db_tick = (c % 4 == 3);
      step(1);
    end
    db_tick = 1'b0;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check("rst_stat", irq_stat, '0);
    check("rst_irq", W'(irq), '0);
    check("rst_din", din, exp_din());
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    // Push-pull outputs on the low byte, inputs on the high byte.
    dir     = 16'hFF00;
    dout    = 16'hA5A5;
    ext_val = 16'h3C00;
    pulse_reset();
    step(4);
    check("pp_pad_lo", {8'h00, pad[7:0]}, 16'h00A5);
    check("pp_din_lo", {8'h00, din[7:0]}, 16'h00A5);

    // Bit 0 open-drain with an external pull-up, then forced low externally.
    dir = 16'hFFFE; od = 16'h0001; dout = 16'h0001; ext_val = 16'h0001;
    step(4);
    ext_val[0] = 1'b0;
    step(3);
    check("od_din0", W'(din[0]), '0);
    ext_val[0] = 1'b1;
    dout[0] = 1'b0;
    step(1);
    check("od_pad0", W'(pad[0]), '0);

    // Bit 3 debounce: a two-tick glitch is rejected, a three-tick level is accepted.
    dir = '1; od = '0; dout = '0; ext_val = '0;
    db_en[3] = 1'b1; db_thresh = 4'd2;
    step(4);
    ext_val[3] = 1'b1;
    run_ticks(8);
    ext_val[3] = 1'b0;
    run_ticks(8);
    check("db_glitch", W'(din[3]), '0);
    ext_val[3] = 1'b1;
    run_ticks(16);
    check("db_accept", W'(din[3]), W'(1));
    db_en = '0;

    // Edge types: bit 5 rising, bit 6 falling, bit 7 both.
    ext_val = '0;
    step(4);
    irq_type[11:10] = 2'b00; irq_type[13:12] = 2'b01; irq_type[15:14] = 2'b10;
    irq_en[7:5] = 3'b111;
    ext_val[7:5] = 3'b111;
    step(6);
    check("edge_rise", W'(irq_stat[7:5]), W'(3'b101));
    ext_val[7:5] = 3'b000;
    step(6);
    check("edge_fall", W'(irq_stat[7:5]), W'(3'b111));

    // Bit 2 level-high: clear is ineffective while the pin is high.
    irq_type[5:4] = 2'b11; irq_en[2] = 1'b1; ext_val[2] = 1'b1;
    step(5);
    irq_clr[2] = 1'b1;
    step(1);
    irq_clr = '0;
    check("lvl_hold", W'(irq_stat[2]), W'(1));
    ext_val[2] = 1'b0;
    step(4);
    irq_clr = '1;
    step(1);
    irq_clr = '0;
    check("lvl_clear", irq_stat, '0);
    check("lvl_irq", W'(irq), '0);

    // Bit 1: clear pulse lands on the same edge as the rising event.
    irq_type[3:2] = 2'b00; irq_en[1] = 1'b1; ext_val[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      irq_clr[1] = (c == 3);
      step(1);
    end
    irq_clr = '0;
    check("set_wins", W'(irq_stat[1]), W'(1));

    // Reset in the middle of a debounce count.
    db_en[4] = 1'b1; db_thresh = 4'd5; ext_val[4] = 1'b1;
    run_ticks(10);
    pulse_reset();
    step(2);

    // Randomised traffic with occasional reconfiguration.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        dir       = W'($urandom);
        od        = W'($urandom);
        db_en     = W'($urandom);
        irq_en    = W'($urandom);
        irq_type  = $urandom;
        db_thresh = CW'($urandom_range(0, 3));
      end
      if (c % 7 == 0) dout = W'($urandom);
      ext_val = ext_val ^ (W'($urandom) & W'($urandom) & W'($urandom));
      irq_clr = W'($urandom) & W'($urandom) & W'($urandom);
      db_tick = ($urandom_range(0, 3) == 0);
      step(1);
      if (c == 1777) pulse_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
